// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer RAM arbiter: display line refill (priority) versus a pixel writer.
// Optional statistics counters are enabled with `define LCD_FB_ARB_STATS_EN.

module lcd_fb_arbiter #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              line_req,
  input  logic [9:0]        line_y,
  input  logic              fifo_afull,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              line_done,
  output logic              busy,
  output logic              err_req
`ifdef LCD_FB_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_stall_cycles,
  output logic [15:0]       stat_bursts
`endif
);

  localparam int unsigned CntW    = $clog2(H_ACTIVE + 1);
  localparam int unsigned BeatW   = $clog2(BURST_LEN + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CntW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [BeatW-1:0]    beats_q, beats_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                hold_q;
  logic                pix_valid_q;
  logic                line_done_q;

  logic                rd_strobe;
  logic                line_ok;
  logic                starve_hit;
  logic                last_pix;
  logic [ADDR_W-1:0]   line_base;
  logic [31:0]         rem_pix;
  logic [BeatW-1:0]    next_beats;

  assign line_ok    = 32'(line_y) < V_ACTIVE;
  assign starve_hit = 32'(starve_q) >= STARVE_MAX;
  assign last_pix   = 32'(pix_cnt_q) == (H_ACTIVE - 1);
  assign line_base  = ADDR_W'(32'(line_y) * H_ACTIVE);
  assign rem_pix    = H_ACTIVE - 32'(pix_cnt_q);
  assign next_beats = BeatW'((rem_pix < BURST_LEN) ? rem_pix : BURST_LEN);

  // hold_q marks the first cycle after reset, in which every output stays quiet.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    pix_cnt_d = pix_cnt_q;
    beats_d   = beats_q;
    wr_ready  = 1'b0;
    err_req   = 1'b0;
    rd_strobe = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (!hold_q) begin
      unique case (state_q)
        StIdle: begin
          wr_ready = 1'b1;
          if (line_req) begin
            if (line_ok) begin
              base_d    = line_base;
              pix_cnt_d = '0;
              state_d   = StWait;
            end else begin
              err_req = 1'b1;
            end
          end
        end
        StWait: begin
          err_req = line_req;
          if (starve_hit && wr_valid) begin
            wr_ready = 1'b1;
          end else if (!fifo_afull) begin
            beats_d = next_beats;
            state_d = StBurst;
          end else if (wr_valid) begin
            wr_ready = 1'b1;
          end
        end
        StBurst: begin
          err_req   = line_req;
          rd_strobe = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = base_q + ADDR_W'(pix_cnt_q);
          pix_cnt_d = pix_cnt_q + CntW'(1);
          beats_d   = beats_q - BeatW'(1);
          if (beats_q == BeatW'(1)) begin
            state_d = last_pix ? StIdle : StWait;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (wr_valid && wr_ready) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle || (wr_valid && wr_ready)) begin
      starve_d = '0;
    end else if (wr_valid && !starve_hit) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      pix_cnt_q   <= '0;
      beats_q     <= '0;
      starve_q    <= '0;
      hold_q      <= 1'b1;
      pix_valid_q <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      pix_cnt_q   <= pix_cnt_d;
      beats_q     <= beats_d;
      starve_q    <= starve_d;
      hold_q      <= 1'b0;
      pix_valid_q <= rd_strobe;
      line_done_q <= rd_strobe && last_pix;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_valid_q ? mem_rdata : '0;
  assign line_done = line_done_q;
  assign busy      = (state_q != StIdle);

`ifdef LCD_FB_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] bursts_q;
  logic        stall_ev;
  logic        burst_start;

  assign stall_ev    = wr_valid && !wr_ready;
  assign burst_start = (state_q == StWait) && (state_d == StBurst);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || stat_clr) begin
      stall_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (stall_ev && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (burst_start && (bursts_q != 16'hFFFF)) begin
        bursts_q <= bursts_q + 16'd1;
      end
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_bursts       = bursts_q;
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Self-checking bench for lcd_fb_arbiter: directed vectors, corner sequences and a random soak
// checked by an event-level line-fetch model.

module tb_lcd_fb_arbiter;

  localparam int H  = 32;
  localparam int V  = 4;
  localparam int AW = 12;
  localparam int DW = 24;
  localparam int B  = 8;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          line_req;
  logic [9:0]    line_y;
  logic          fifo_afull;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          line_done;
  logic          busy;
  logic          err_req;
  logic          stat_clr;
`ifdef LCD_FB_ARB_STATS_EN
  logic [15:0]   stat_stall_cycles;
  logic [15:0]   stat_bursts;
`endif

  lcd_fb_arbiter #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_LEN (B),
    .STARVE_MAX(S)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (sys_rst_n),
    .line_req  (line_req),
    .line_y    (line_y),
    .fifo_afull(fifo_afull),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .line_done (line_done),
    .busy      (busy),
    .err_req   (err_req)
`ifdef LCD_FB_ARB_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_stall_cycles(stat_stall_cycles),
    .stat_bursts      (stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rdata_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = rdata_q;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Line-fetch model: expected read order, data captured at issue, busy window, stall stats.
  logic [DW-1:0] exp_q[$];
  bit            last_q[$];
  bit            busy_exp = 0;
  bit            post_rst = 0;
  bit            prev_read = 0;
  bit            prev_afull = 0;
  int            exp_base = 0;
  int            rd_idx = 0;
  int            cons_stall = 0;
  int            first_rd_addr = -1;
  int            grants_busy = 0;
  int            stall_total = 0;
  int            bursts_total = 0;

  always @(negedge clk) begin
    bit rd;
    rd = mem_en && !mem_we;
    if (!sys_rst_n) begin
      exp_q.delete();
      last_q.delete();
      busy_exp = 0; rd_idx = 0; post_rst = 1; prev_read = 0; cons_stall = 0;
      stall_total = 0; bursts_total = 0;
    end else begin
      if (post_rst) begin
        check("post_reset_quiet", |{mem_en, mem_we, mem_addr, mem_wdata, pix_valid, pix_data,
                                   line_done, busy, err_req, wr_ready}, 0);
        post_rst = 0;
      end else begin
        if (line_req || err_req)
          check("err_req", err_req, line_req && (busy_exp || int'(line_y) >= V));
        check("busy", busy, busy_exp);
        if (wr_valid && wr_ready)
          check("write_port", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, wr_addr, wr_data});
        else if (mem_en && mem_we)
          check("spurious_write", 1, 0);
        if (rd) begin
          check("read_in_line", busy_exp, 1);
          check("read_addr", mem_addr, 64'(exp_base + rd_idx));
          check("wr_ready_during_read", wr_ready, 0);
          if (!prev_read) begin
            check("burst_start_afull", prev_afull, 0);
            bursts_total++;
          end
          if (rd_idx == 0) first_rd_addr = int'(mem_addr);
          exp_q.push_back(ram[mem_addr]);
          last_q.push_back(rd_idx == H - 1);
          rd_idx++;
        end
        if (pix_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pix_valid", 1, 0);
          end else begin
            check("pix_data", pix_data, exp_q.pop_front());
            check("line_done", line_done, last_q.pop_front());
          end
        end else if (line_done) begin
          check("line_done_without_pix", 1, 0);
        end
        if (wr_valid && !wr_ready) begin
          cons_stall++;
        end else begin
          if (cons_stall > 0) check("starve_bound", cons_stall <= B + 1, 1);
          cons_stall = 0;
          if (wr_valid && busy_exp) grants_busy++;
        end
        if (line_req && !busy_exp && int'(line_y) < V) begin
          busy_exp = 1;
          exp_base = int'(line_y) * H;
          rd_idx   = 0;
        end
        if (rd && rd_idx == H) busy_exp = 0;
        prev_read = rd;
      end
      prev_afull = fifo_afull;
      if (stat_clr) begin
        stall_total = 0; bursts_total = 0;
      end else if (wr_valid && !wr_ready) begin
        stall_total++;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input int y);
    line_req = 1'b1;
    line_y   = 10'(y);
    @(negedge clk);
    next_cyc();
    line_req = 1'b0;
  endtask

  // Returns the cycle index (req cycle = 0) at which line_done is seen, or -1 on timeout.
  task automatic wait_done(input int start, input int budget, output int at);
    int c;
    c  = start;
    at = -1;
    while (c < start + budget) begin
      @(negedge clk);
      if (line_done) begin
        at = c;
        break;
      end
      next_cyc();
      c++;
    end
  endtask

  typedef struct {
    int y;
    bit err;
    int base;
    int done_cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    bit any_pv;
    logic [DW-1:0] wd;

    for (int i = 0; i < 4096; i++) ram[i] <= DW'(i);
    tbl[0] = '{2,    1'b0, 64, 37};
    tbl[1] = '{0,    1'b0, 0,  37};
    tbl[2] = '{3,    1'b0, 96, 37};
    tbl[3] = '{4,    1'b1, 0,  0};
    tbl[4] = '{1023, 1'b1, 0,  0};
    tbl[5] = '{1,    1'b0, 32, 37};

    sys_rst_n = 1'b0; line_req = 1'b0; line_y = '0; fifo_afull = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    next_cyc();

    // Vector table: line requests from idle, valid and out of range.
    for (int i = 0; i < 6; i++) begin
      line_req = 1'b1;
      line_y   = 10'(tbl[i].y);
      @(negedge clk);
      check("tbl_err", err_req, tbl[i].err);
      next_cyc();
      line_req = 1'b0;
      if (!tbl[i].err) begin
        wait_done(1, 80, at);
        check("tbl_done_cycle", at, tbl[i].done_cyc);
        if (at >= 0) begin
          check("tbl_busy_after_line", busy, 0);
          check("tbl_first_addr", first_rd_addr, tbl[i].base);
          next_cyc();
        end
      end else begin
        next_cyc();
      end
    end

    // Starvation guard: writer held during a full line fetch.
    stat_clr = 1'b1;
    next_cyc();
    stat_clr = 1'b0;
    wr_valid = 1'b1; wr_addr = 12'd200; wr_data = 24'hABCDE;
    grants_busy = 0;
    issue_req(1);
    wait_done(1, 80, at);
    check("starve_done_cycle", at, 40);
    if (at >= 0) next_cyc();
    wr_valid = 1'b0;
    check("starve_grants_in_line", grants_busy, 3);
    next_cyc();
    next_cyc();
    check("write_landed", ram[200], 24'hABCDE);
`ifdef LCD_FB_ARB_STATS_EN
    check("stat_bursts", stat_bursts, 4);
    check("stat_stall_cycles", stat_stall_cycles, 64'(stall_total));
    stat_clr = 1'b1;
    next_cyc();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_clr_zero", {stat_bursts, stat_stall_cycles}, 0);
    next_cyc();
`endif

    // Almost-full held after the first burst: writes every wait cycle, no reads.
    issue_req(1);
    next_cyc();
    fifo_afull = 1'b1; wr_valid = 1'b1; wr_addr = 12'd300; wr_data = 24'h123456;
    repeat (8) next_cyc();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("afull_wait_grant", {wr_ready, mem_en && !mem_we}, 2'b10);
      next_cyc();
    end
    fifo_afull = 1'b0; wr_valid = 1'b0;
    next_cyc();
    @(negedge clk);
    check("afull_resume_addr", {mem_en, mem_we, mem_addr}, {2'b10, 12'd40});
    next_cyc();
    wait_done(18, 60, at);
    check("afull_line_completes", at >= 0, 1);
    if (at >= 0) next_cyc();

    // Rejected requests while busy leave the fetch untouched.
    issue_req(0);
    next_cyc();
    next_cyc();
    line_req = 1'b1; line_y = 10'd3;
    @(negedge clk);
    check("err_busy", err_req, 1);
    check("err_busy_addr", mem_addr, 1);
    next_cyc();
    line_req = 1'b0;
    @(negedge clk);
    check("err_one_pulse", err_req, 0);
    check("err_next_addr", mem_addr, 2);
    next_cyc();
    line_req = 1'b1; line_y = 10'd4;
    @(negedge clk);
    check("err_range_busy", err_req, 1);
    next_cyc();
    line_req = 1'b0;
    wait_done(6, 60, at);
    check("err_no_disturb", at, 37);
    if (at >= 0) next_cyc();

    // Reset mid-burst, then a clean fetch of line 0.
    issue_req(3);
    repeat (4) next_cyc();
    sys_rst_n = 1'b0;
    next_cyc();
    sys_rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs_zero", {mem_en, mem_we, mem_addr, mem_wdata, pix_valid, pix_data,
                                 line_done, busy, err_req, wr_ready}, 0);
    next_cyc();
    any_pv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any_pv |= pix_valid;
      next_cyc();
    end
    check("reset_no_pix_valid", any_pv, 0);
    first_rd_addr = -1;
    issue_req(0);
    wait_done(1, 80, at);
    check("reset_refetch_done", at, 37);
    check("reset_refetch_first", first_rd_addr, 0);
    if (at >= 0) next_cyc();

    // Random soak against the model.
    for (int i = 0; i < 3000; i++) begin
      fifo_afull = ($urandom_range(0, 9) < 3);
      wr_valid   = $urandom_range(0, 1) == 1;
      wr_addr    = AW'($urandom_range(0, 127));
      wd         = DW'($urandom);
      wr_data    = wd;
      line_req   = ($urandom_range(0, 19) == 0);
      line_y     = 10'($urandom_range(0, 5));
      next_cyc();
    end
    fifo_afull = 1'b0; wr_valid = 1'b0; line_req = 1'b0;
    for (int i = 0; i < 200 && busy; i++) next_cyc();
    next_cyc();
    check("drain_idle", busy, 0);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
